// File: rtl/icache_fetch_unit_pkg.sv
// icache_fetch_unit_pkg: shared bus constants, line geometry and refill state type
package icache_fetch_unit_pkg;
  localparam int ADDRESS_SIZE = 64;
  localparam int INSTRUCTION_SIZE = 32;
  localparam int DATA_SIZE = 64;
  localparam logic SYSBUS_READ = 1'b1;
  localparam logic SYSBUS_WRITE = 1'b0;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam int LINE_BYTES_DEF = 64;
  localparam int LINE_BEATS = LINE_BYTES_DEF * 8 / DATA_SIZE;
  typedef enum logic [1:0] {IDLE, REQ, RESP} fill_state_e;
endpackage

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: issues the line read on the bus and assembles the returned beats
module icache_refill_fsm
  import icache_fetch_unit_pkg::*;
#(
  parameter int BEATS = LINE_BEATS,
  parameter int TAG_W = 13
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDRESS_SIZE-1:0]       start_addr,
  input  logic                          bus_reqack,
  input  logic                          bus_respcyc,
  input  logic [DATA_SIZE-1:0]          bus_resp,
  output logic                          bus_reqcyc,
  output logic [ADDRESS_SIZE-1:0]       bus_req,
  output logic [TAG_W-1:0]              bus_reqtag,
  output logic                          bus_respack,
  output logic                          fill_done,
  output logic [ADDRESS_SIZE-1:0]       fill_addr,
  output logic [BEATS*DATA_SIZE-1:0]    fill_data
);
  localparam int CW = $clog2(BEATS);
  localparam logic [ADDRESS_SIZE-1:0] LINE_MASK = ADDRESS_SIZE'(BEATS * DATA_SIZE / 8 - 1);
  fill_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [BEATS*DATA_SIZE-1:0] line_q, line_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
    end
  end
  always_ff @(posedge clk) line_q <= line_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    line_d = line_q;
    fill_done = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        addr_d = start_addr & ~LINE_MASK;
      end
      REQ: if (bus_reqack) begin
        state_d = RESP;
        cnt_d = '0;
      end
      RESP: if (bus_respcyc) begin
        line_d[cnt_q*DATA_SIZE +: DATA_SIZE] = bus_resp;
        cnt_d = cnt_q + 1'b1;
        fill_done = cnt_q == CW'(BEATS - 1);
        state_d = fill_done ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus_reqcyc = !reset && state_q == REQ;
  assign bus_req = bus_reqcyc ? addr_q : '0;
  assign bus_reqtag = bus_reqcyc ? TAG_W'({SYSBUS_READ, SYSBUS_MEMORY, 8'h00}) : '0;
  assign bus_respack = bus_respcyc;
  assign fill_addr = addr_q;
  assign fill_data = line_d;
endmodule

// File: rtl/icache_fetch_unit.sv
// icache_fetch_unit: direct-mapped read-only instruction cache with bus line refill
module icache_fetch_unit
  import icache_fetch_unit_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int NUM_LINES = 64,
  parameter int LINE_BYTES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        instruction_read,
  input  logic [ADDRESS_SIZE-1:0]     instruction_address,
  output logic [INSTRUCTION_SIZE-1:0] instruction_response,
  output logic                        busy,
  input  logic                        mem_read,
  input  logic                        mem_write,
  output logic                        bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]   bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
  input  logic                        bus_reqack,
  input  logic                        bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
  output logic                        bus_respack
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDRESS_SIZE - OFF_W - IDX_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BEATS = LINE_W / BUS_DATA_WIDTH;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [NUM_LINES];
  logic [LINE_W-1:0] data_q [NUM_LINES];
  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-3:0] word_sel;
  logic hit, fill_done;
  logic [ADDRESS_SIZE-1:0] fill_addr;
  logic [LINE_W-1:0] fill_data;
  logic unused_ok;
  assign idx = instruction_address[OFF_W +: IDX_W];
  assign tag = instruction_address[ADDRESS_SIZE-1 -: TAG_W];
  assign word_sel = instruction_address[OFF_W-1:2];
  assign fill_idx = fill_addr[OFF_W +: IDX_W];
  assign hit = !reset && instruction_read && valid_q[idx] && tag_q[idx] == tag;
  assign busy = !reset && instruction_read && !hit;
  assign instruction_response = hit ? data_q[idx][word_sel*INSTRUCTION_SIZE +: INSTRUCTION_SIZE] : '0;
  assign unused_ok = ^{mem_read, mem_write, bus_resptag, instruction_address[1:0], fill_addr[OFF_W-1:0]};
  always_comb begin
    valid_d = valid_q;
    if (fill_done) valid_d[fill_idx] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else valid_q <= valid_d;
  end
  always_ff @(posedge clk) begin
    if (fill_done && !reset) begin
      tag_q[fill_idx] <= fill_addr[ADDRESS_SIZE-1 -: TAG_W];
      data_q[fill_idx] <= fill_data;
    end
  end
  icache_refill_fsm #(.BEATS(BEATS), .TAG_W(BUS_TAG_WIDTH)) u_refill (
    .clk(clk),
    .reset(reset),
    .start(busy),
    .start_addr(instruction_address),
    .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp),
    .bus_reqcyc(bus_reqcyc),
    .bus_req(bus_req),
    .bus_reqtag(bus_reqtag),
    .bus_respack(bus_respack),
    .fill_done(fill_done),
    .fill_addr(fill_addr),
    .fill_data(fill_data)
  );
endmodule

// File: tb/tb_icache_fetch_unit.sv
// tb_icache_fetch_unit: directed vectors and refill sequences for the instruction cache
module tb_icache_fetch_unit;
  logic clk = 1'b0;
  logic reset, instruction_read, mem_read, mem_write;
  logic [63:0] instruction_address;
  logic [31:0] instruction_response;
  logic busy, bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;
  int passed = 0;
  int total = 0;
  typedef struct {
    logic rd;
    logic [63:0] addr;
    logic busy;
    logic [31:0] resp;
  } vec_t;
  vec_t vecs [9];
  always #5 clk = ~clk;
  icache_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .instruction_read(instruction_read),
    .instruction_address(instruction_address),
    .instruction_response(instruction_response),
    .busy(busy),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .bus_reqcyc(bus_reqcyc),
    .bus_req(bus_req),
    .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp(bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  task automatic req_phase(input logic [63:0] line);
    #1;
    chk("reqcyc", bus_reqcyc, 1);
    chk("req_addr", bus_req, line);
    chk("reqtag", bus_reqtag, 13'h1100);
    tick();
    #1;
    chk("reqcyc_hold", bus_reqcyc, 1);
    chk("req_addr_hold", bus_req, line);
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    #1;
    chk("reqcyc_drop", bus_reqcyc, 0);
    chk("req_drop", bus_req, 0);
  endtask
  task automatic feed(input logic [31:0] base, input int first, input int n, input logic exp_busy);
    for (int k = first; k < first + n; k++) begin
      bus_respcyc = 1'b1;
      bus_resp = {base + 32'(2*k + 1), base + 32'(2*k)};
      #1;
      chk("respack", bus_respack, 1);
      chk("busy_fill", busy, exp_busy);
      chk("reqcyc_fill", bus_reqcyc, 0);
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resp = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    vecs[0] = '{1'b1, 64'h1004, 1'b0, 32'h1};
    vecs[1] = '{1'b1, 64'h1008, 1'b0, 32'h2};
    vecs[2] = '{1'b1, 64'h103C, 1'b0, 32'hF};
    vecs[3] = '{1'b1, 64'h1001, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 64'h1023, 1'b0, 32'h8};
    vecs[5] = '{1'b1, 64'h101E, 1'b0, 32'h7};
    vecs[6] = '{1'b0, 64'h1004, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 64'h9000, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 64'h1030, 1'b0, 32'hC};
    reset = 1'b1;
    instruction_read = 1'b0;
    instruction_address = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    bus_reqack = 1'b0;
    bus_respcyc = 1'b1;
    bus_resp = 64'hDEAD;
    bus_resptag = '0;
    tick();
    tick();
    chk("rst_respack", bus_respack, 1);
    chk("rst_busy", busy, 0);
    chk("rst_reqcyc", bus_reqcyc, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_reqtag", bus_reqtag, 0);
    chk("rst_resp", instruction_response, 0);
    instruction_read = 1'b1;
    instruction_address = 64'h1000;
    #1;
    chk("rst_busy_read", busy, 0);
    tick();
    reset = 1'b0;
    bus_respcyc = 1'b0;
    #1;
    chk("miss_busy", busy, 1);
    chk("miss_resp", instruction_response, 0);
    chk("miss_idle_reqcyc", bus_reqcyc, 0);
    tick();
    req_phase(64'h1000);
    feed(32'h0, 0, 8, 1'b1);
    #1;
    chk("hit0_busy", busy, 0);
    chk("hit0_resp", instruction_response, 0);
    chk("hit0_reqcyc", bus_reqcyc, 0);
    for (int i = 0; i < 9; i++) begin
      instruction_read = vecs[i].rd;
      instruction_address = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_resp", i), instruction_response, vecs[i].resp);
      chk($sformatf("vec%0d_reqcyc", i), bus_reqcyc, 0);
      tick();
    end
    instruction_read = 1'b1;
    instruction_address = 64'h2000;
    #1;
    chk("conflict_busy", busy, 1);
    tick();
    req_phase(64'h2000);
    feed(32'h100, 0, 8, 1'b1);
    #1;
    chk("conf_hit_busy", busy, 0);
    chk("conf_hit_resp", instruction_response, 32'h100);
    instruction_address = 64'h2014;
    #1;
    chk("conf_hit_w5", instruction_response, 32'h105);
    instruction_address = 64'h1000;
    #1;
    chk("evicted_busy", busy, 1);
    chk("evicted_resp", instruction_response, 0);
    tick();
    req_phase(64'h1000);
    feed(32'h0, 0, 3, 1'b1);
    instruction_address = 64'h3000;
    feed(32'h0, 3, 5, 1'b1);
    #1;
    chk("switch_busy", busy, 1);
    chk("switch_idle_reqcyc", bus_reqcyc, 0);
    tick();
    instruction_address = 64'h1008;
    #1;
    chk("latched_fill_busy", busy, 0);
    chk("latched_fill_resp", instruction_response, 32'h2);
    chk("next_req_cyc", bus_reqcyc, 1);
    chk("next_req_addr", bus_req, 64'h3000);
    instruction_address = 64'h3000;
    req_phase(64'h3000);
    feed(32'h200, 0, 4, 1'b1);
    reset = 1'b1;
    bus_respcyc = 1'b1;
    bus_resp = 64'h0000_0209_0000_0208;
    #1;
    chk("midrst_respack", bus_respack, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_reqcyc", bus_reqcyc, 0);
    tick();
    reset = 1'b0;
    instruction_read = 1'b0;
    feed(32'h200, 5, 3, 1'b0);
    instruction_read = 1'b1;
    #1;
    chk("aborted_busy", busy, 1);
    chk("aborted_reqcyc", bus_reqcyc, 0);
    instruction_address = 64'h1000;
    #1;
    chk("cleared_busy", busy, 1);
    tick();
    req_phase(64'h1000);
    feed(32'h300, 0, 7, 1'b1);
    reset = 1'b1;
    bus_respcyc = 1'b1;
    bus_resp = 64'h0000_030F_0000_030E;
    #1;
    chk("lastrst_respack", bus_respack, 1);
    tick();
    reset = 1'b0;
    bus_respcyc = 1'b0;
    #1;
    chk("lastrst_busy", busy, 1);
    chk("lastrst_resp", instruction_response, 0);
    instruction_read = 1'b0;
    #1;
    chk("noread_busy", busy, 0);
    chk("noread_resp", instruction_response, 0);
    chk("noread_reqcyc", bus_reqcyc, 0);
    tick();
    #1;
    chk("noread_reqcyc2", bus_reqcyc, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/icache_fetch_unit.md
Name: icache_fetch_unit

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and the 64-bit system bus.
- Returns a 32-bit instruction combinationally on a hit.
- On a miss it raises busy, fetches the 64-byte line over the bus, fills it, and then hits.
- Data-side ports (mem_read, mem_write) are present for interface compatibility only; the data path is out of scope for this block.

Parameters:
- BUS_DATA_WIDTH, 64, bus data width; fixed at 64.
- BUS_TAG_WIDTH, 13, bus tag width.
- NUM_LINES, 64, number of direct-mapped lines (power of 2).
- LINE_BYTES, 64, bytes per line; a refill is 8 bus beats.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instruction_read  in  1  fetch request this cycle.
- instruction_address  in  64  byte address of the instruction; bits [1:0] are ignored.
- instruction_response  out  32  instruction word.
- busy  out  1  miss in progress or pending; the consumer must stall.
- mem_read  in  1  reserved; must be 0; ignored.
- mem_write  in  1  reserved; must be 0; ignored.
- bus_reqcyc  out  1  bus request valid.
- bus_req  out  BUS_DATA_WIDTH  request address, line-aligned.
- bus_reqtag  out  BUS_TAG_WIDTH  {1'b1 READ, 4'b0001 MEMORY, 8'h00}.
- bus_reqack  in  1  bus accepted the request.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  BUS_DATA_WIDTH  response data beat.
- bus_resptag  in  BUS_TAG_WIDTH  response tag; not checked.
- bus_respack  out  1  response beat acknowledged.

Behaviour:
- Address split: offset [5:0], index [5+log2(NUM_LINES):6], tag = remaining upper bits.
- Per line: valid bit, tag, and 512 bits of data.
- hit = instruction_read && valid[index] && tag match.
- instruction_response = hit ? word[offset[5:2]] : 32'h0. Word 0 is the lowest address. Layout is little-endian: beat k holds bytes 8k..8k+7, with the lower word in bits [31:0].
- busy = instruction_read && !hit, combinational and in the same cycle. busy = 0 whenever instruction_read = 0.
- FSM states: IDLE, REQ, RESP.
- IDLE → REQ: on a miss (busy=1 in IDLE). Latch line address = {address[63:6], 6'b0}.
- REQ: bus_reqcyc=1, bus_req=latched line address, bus_reqtag as above. Hold these until bus_reqack=1, then go to RESP. bus_reqcyc drops the cycle after ack.
- RESP: each cycle with bus_respcyc=1, store bus_resp into beat counter slot (0..7) and assert bus_respack=1 in the same cycle.
- After the 8th beat: write the line, set valid, update the tag, go to IDLE. The access hits the next cycle, so miss latency = handshake cycles + 8 beats + 1.
- Address changes during a refill: the refill completes for the latched line; busy reflects the current address against the current array contents.
- respcyc in IDLE or REQ (stray beats, e.g. after reset): acknowledge with respack=1 and discard.
- No new request is issued until the FSM returns to IDLE.
- Reset, including mid-refill: clears all valid bits, FSM → IDLE, beat counter → 0.
- Reset output values: bus_reqcyc=0, bus_req=0, bus_reqtag=0, busy=0, instruction_response=0. bus_respack follows the stray-beat rule.
- Reset priority: reset overrides any fill completing in the same cycle; that line is not marked valid.
- Outputs are 0 when not asserted.

Decomposition:
- Shared package: ADDRESS_SIZE=64, INSTRUCTION_SIZE=32, DATA_SIZE=64, SYSBUS_READ/WRITE/MEMORY tag constants, line and beat count constants.
- One natural sub-module: icache_refill_fsm (request/response handshake, beat counter, line buffer). The tag/data array and hit logic stay in the top level.

Test Plan:
- Reset, then read=1 at addr 0x1000 → busy=1 same cycle; bus_reqcyc=1, bus_req=0x1000, bus_reqtag=0x1100 until reqack.
- Feed 8 beats, beat k = {32'h(2k+1), 32'h(2k)}, respcyc held high → respack=1 on each beat. The next cycle, addr 0x1000 gives 0x0 with busy=0, 0x1004 gives 0x1, and 0x103C gives 0xF, all with no bus traffic.
- Conflict: read 0x2000 (same index, different tag) → miss and refill. Afterwards 0x1000 misses again.
- Change instruction_address to 0x3000 mid-refill of 0x1000 → the 0x1000 line fills; busy stays 1; a new request for 0x3000 issues after returning to IDLE.
- Assert reset after 4 beats → the line is not valid; respack stays 1 on the remaining stray beats; re-reading 0x1000 issues a fresh request.
- instruction_read=0 on any address → busy=0, response=0, bus_reqcyc=0.
